// File: rtl/i2s_slave_rx_pkg.sv
// i2s_pkg: receiver FSM states, channel encoding and output word width shared with the TX side
package i2s_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PAD} rx_state_t;
  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} i2s_ch_t;
  localparam int I2S_WORD_W = 32;
endpackage

// File: rtl/i2s_slave_rx_if.sv
// i2s_slave_rx_if: external I2S pins plus the sample valid/ready stream and status pulses
interface i2s_slave_rx_if;
  import i2s_pkg::*;
  logic                  i2s_sck_i;
  logic                  i2s_ws_i;
  logic                  i2s_sd_i;
  logic [I2S_WORD_W-1:0] sample_dat_o;
  logic                  sample_ch_o;
  logic                  sample_valid_o;
  logic                  sample_ready_i;
  logic                  overrun_o;
  logic                  short_word_o;
  modport slave (
    input  i2s_sck_i, i2s_ws_i, i2s_sd_i, sample_ready_i,
    output sample_dat_o, sample_ch_o, sample_valid_o, overrun_o, short_word_o
  );
  modport master (
    output i2s_sck_i, i2s_ws_i, i2s_sd_i, sample_ready_i,
    input  sample_dat_o, sample_ch_o, sample_valid_o, overrun_o, short_word_o
  );
endinterface

// File: rtl/i2s_slave_rx_sync.sv
// i2s_rx_sync: synchronizes SCK/WS/SD into the system clock and flags SCK rising edges
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sck,
  input  logic i_ws,
  input  logic i_sd,
  output logic o_sck_rise,
  output logic o_ws_s,
  output logic o_sd_s
);
  logic [SYNC_STAGES-1:0] r_sck;
  logic [SYNC_STAGES-1:0] r_ws;
  logic [SYNC_STAGES-1:0] r_sd;
  logic                   r_sck_hist;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck      <= '0;
      r_ws       <= '0;
      r_sd       <= '0;
      r_sck_hist <= 1'b0;
    end else begin
      r_sck      <= {r_sck[SYNC_STAGES-2:0], i_sck};
      r_ws       <= {r_ws[SYNC_STAGES-2:0], i_ws};
      r_sd       <= {r_sd[SYNC_STAGES-2:0], i_sd};
      r_sck_hist <= r_sck[SYNC_STAGES-1];
    end
  end
  assign o_sck_rise = r_sck[SYNC_STAGES-1] & ~r_sck_hist;
  assign o_ws_s     = r_ws[SYNC_STAGES-1];
  assign o_sd_s     = r_sd[SYNC_STAGES-1];
endmodule

// File: rtl/i2s_slave_rx.sv
// i2s_slave_rx: I2S slave deserializer with valid/ready output; I2S_SLAVE_RX_FIFO_EN swaps the
// single output register for a FIFO_DEPTH-entry FIFO.
module i2s_slave_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic             lmmi_clk_i,
  input logic             reset_i,
  input logic             en_i,
  i2s_slave_rx_if.slave   i2s
);
  localparam int CW = $clog2(DATA_WIDTH);
  logic                  w_sck_rise, w_ws_s, w_sd_s, w_ws_edge;
  logic                  r_ws_prev;
  rx_state_t             r_state, w_state_nx;
  logic [CW-1:0]         r_bit_cnt, w_bit_cnt_nx;
  logic [DATA_WIDTH-1:0] r_shreg, w_shreg_nx, w_data;
  i2s_ch_t               r_ch, w_ch_nx;
  logic                  w_done, w_short, w_over;
  logic [I2S_WORD_W-1:0] w_word;
  logic                  r_overrun, r_short;
  i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (lmmi_clk_i),
    .rst        (reset_i),
    .i_sck      (i2s.i2s_sck_i),
    .i_ws       (i2s.i2s_ws_i),
    .i_sd       (i2s.i2s_sd_i),
    .o_sck_rise (w_sck_rise),
    .o_ws_s     (w_ws_s),
    .o_sd_s     (w_sd_s)
  );
  assign w_ws_edge = w_sck_rise && (w_ws_s != r_ws_prev);
  always_ff @(posedge lmmi_clk_i or posedge reset_i) begin
    if (reset_i) r_ws_prev <= 1'b0;
    else if (w_sck_rise) r_ws_prev <= w_ws_s;
  end
  // The edge carrying a WS change holds the previous slot's LSB, so it only (re)starts a word.
  always_comb begin
    w_state_nx   = r_state;
    w_bit_cnt_nx = r_bit_cnt;
    w_shreg_nx   = r_shreg;
    w_ch_nx      = r_ch;
    w_done       = 1'b0;
    w_short      = 1'b0;
    w_data       = r_shreg;
    if (!en_i) begin
      w_state_nx   = IDLE;
      w_bit_cnt_nx = '0;
      w_shreg_nx   = '0;
    end else if (w_sck_rise) begin
      case (r_state)
        SHIFT: begin
          if (w_ws_edge) begin
            w_done  = 1'b1;
            w_short = 1'b1;
            w_data  = r_shreg << (DATA_WIDTH - r_bit_cnt);
          end else begin
            w_shreg_nx = {r_shreg[DATA_WIDTH-2:0], w_sd_s};
            w_data     = w_shreg_nx;
            w_done     = r_bit_cnt == CW'(DATA_WIDTH - 1);
            w_state_nx = w_done ? PAD : SHIFT;
            w_bit_cnt_nx = w_done ? r_bit_cnt : r_bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (w_ws_edge) begin
        w_state_nx   = SHIFT;
        w_bit_cnt_nx = '0;
        w_shreg_nx   = '0;
        w_ch_nx      = i2s_ch_t'(w_ws_s);
      end
    end
  end
  always_ff @(posedge lmmi_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_ch      <= CH_LEFT;
    end else begin
      r_state   <= w_state_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_shreg   <= w_shreg_nx;
      r_ch      <= w_ch_nx;
    end
  end
  assign w_word = {{(I2S_WORD_W-DATA_WIDTH){w_data[DATA_WIDTH-1]}}, w_data};
`ifdef I2S_SLAVE_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [I2S_WORD_W:0] r_mem [FIFO_DEPTH];
  logic [AW:0]         r_wr, r_rd;
  logic                w_empty, w_full, w_push, w_pop;
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = w_done && !w_full;
  assign w_pop   = !w_empty && i2s.sample_ready_i;
  assign w_over  = w_done && w_full;
  always_ff @(posedge lmmi_clk_i) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= {r_ch, w_word};
  end
  always_ff @(posedge lmmi_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + (AW+1)'(w_push);
      r_rd <= r_rd + (AW+1)'(w_pop);
    end
  end
  assign i2s.sample_valid_o = !w_empty;
  assign {i2s.sample_ch_o, i2s.sample_dat_o} = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic                  r_valid;
  logic [I2S_WORD_W-1:0] r_dat;
  i2s_ch_t               r_out_ch;
  // A word finishing in the same cycle the held one is accepted still gets loaded.
  assign w_over = w_done && r_valid && !i2s.sample_ready_i;
  always_ff @(posedge lmmi_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_valid  <= 1'b0;
      r_dat    <= '0;
      r_out_ch <= CH_LEFT;
    end else if (w_done && !w_over) begin
      r_valid  <= 1'b1;
      r_dat    <= w_word;
      r_out_ch <= r_ch;
    end else if (i2s.sample_ready_i) begin
      r_valid  <= 1'b0;
    end
  end
  assign i2s.sample_valid_o = r_valid;
  assign i2s.sample_dat_o   = r_dat;
  assign i2s.sample_ch_o    = r_out_ch;
`endif
  always_ff @(posedge lmmi_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_overrun <= 1'b0;
      r_short   <= 1'b0;
    end else begin
      r_overrun <= w_over;
      r_short   <= w_short;
    end
  end
  assign i2s.overrun_o    = r_overrun;
  assign i2s.short_word_o = r_short;
endmodule

// File: tb/tb_i2s_slave_rx.sv
// tb_i2s_slave_rx: drives I2S frames at SCK = clk/8 and checks received samples through a scoreboard
module tb_i2s_slave_rx;
  typedef struct {
    logic        ch;
    logic [23:0] data;
    int          nbits;
    int          pad;
    logic [31:0] exp;
    logic        lat;
  } vec_t;
  typedef struct {
    logic        ch;
    logic [31:0] dat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  int   n_chk = 0, n_err = 0, n_over = 0, n_short = 0;
  exp_t sb[$];
  vec_t tv[8];
  i2s_slave_rx_if bus_if ();
  i2s_slave_rx dut (
    .lmmi_clk_i (clk),
    .reset_i    (rst),
    .en_i       (en),
    .i2s        (bus_if)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  task automatic push(input logic ch, input logic [31:0] d);
    exp_t x;
    x.ch  = ch;
    x.dat = d;
    sb.push_back(x);
  endtask
  task automatic sck_cycle(input logic ws, input logic sd);
    bus_if.i2s_ws_i  = ws;
    bus_if.i2s_sd_i  = sd;
    bus_if.i2s_sck_i = 1'b0;
    repeat (4) @(negedge clk);
    bus_if.i2s_sck_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  // One slot: WS-change bit (sd=1, must be ignored), nbits data MSB first, then pad bits.
  task automatic send_slot(input logic ch, input logic [23:0] data, input int nbits, input int pad,
                           input logic lat);
    sck_cycle(ch, 1'b1);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (lat && i == 0) begin
        bus_if.i2s_sd_i  = data[i];
        bus_if.i2s_sck_i = 1'b0;
        repeat (4) @(negedge clk);
        bus_if.i2s_sck_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("lat_early_valid", {31'b0, bus_if.sample_valid_o}, 32'd0);
        @(negedge clk);
        chk("lat_valid", {31'b0, bus_if.sample_valid_o}, 32'd1);
        @(negedge clk);
        chk("lat_one_pulse", {31'b0, bus_if.sample_valid_o}, 32'd0);
      end else begin
        sck_cycle(ch, data[i]);
      end
    end
    for (int i = 0; i < pad; i++) sck_cycle(ch, 1'b0);
  endtask
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (bus_if.overrun_o) n_over++;
    if (bus_if.short_word_o) n_short++;
    if (bus_if.sample_valid_o && bus_if.sample_ready_i) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_sample: got %h ch %0d, required none",
                 bus_if.sample_dat_o, bus_if.sample_ch_o);
      end else begin
        e = sb.pop_front();
        chk("sample_dat", bus_if.sample_dat_o, e.dat);
        chk("sample_ch", {31'b0, bus_if.sample_ch_o}, {31'b0, e.ch});
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "timeout");
  end
  initial begin
    tv[0] = '{1'b0, 24'h800001, 24, 7, 32'hFF800001, 1'b0};
    tv[1] = '{1'b1, 24'h123456, 24, 7, 32'h00123456, 1'b1};
    tv[2] = '{1'b0, 24'h7FFFFF, 24, 7, 32'h007FFFFF, 1'b0};
    tv[3] = '{1'b1, 24'h000001, 24, 7, 32'h00000001, 1'b0};
    tv[4] = '{1'b0, 24'hFFFFFF, 24, 7, 32'hFFFFFFFF, 1'b0};
    tv[5] = '{1'b1, 24'h00ABCD, 16, 0, 32'hFFABCD00, 1'b0};
    tv[6] = '{1'b0, 24'h654321, 24, 7, 32'h00654321, 1'b0};
    tv[7] = '{1'b1, 24'hA5A5A5, 24, 7, 32'hFFA5A5A5, 1'b0};
    bus_if.i2s_sck_i      = 1'b0;
    bus_if.i2s_ws_i       = 1'b0;
    bus_if.i2s_sd_i       = 1'b0;
    bus_if.sample_ready_i = 1'b1;
    #1;
    chk("rst_valid", {31'b0, bus_if.sample_valid_o}, 32'd0);
    chk("rst_dat", bus_if.sample_dat_o, 32'd0);
    chk("rst_ch", {31'b0, bus_if.sample_ch_o}, 32'd0);
    chk("rst_overrun", {31'b0, bus_if.overrun_o}, 32'd0);
    chk("rst_short", {31'b0, bus_if.short_word_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // WS preamble with the receiver disabled so the first enabled slot starts cleanly.
    sck_cycle(1'b1, 1'b0);
    sck_cycle(1'b1, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(tv[i].ch, tv[i].exp);
      send_slot(tv[i].ch, tv[i].data, tv[i].nbits, tv[i].pad, tv[i].lat);
    end
    chk("short_after_table", n_short, 32'd1);
    bus_if.sample_ready_i = 1'b0;
    push(1'b0, 32'h00111111);
`ifdef I2S_SLAVE_RX_FIFO_EN
    push(1'b1, 32'h00222222);
`endif
    send_slot(1'b0, 24'h111111, 24, 7, 1'b0);
    send_slot(1'b1, 24'h222222, 24, 7, 1'b0);
    chk("held_valid", {31'b0, bus_if.sample_valid_o}, 32'd1);
    chk("held_dat", bus_if.sample_dat_o, 32'h00111111);
    chk("held_ch", {31'b0, bus_if.sample_ch_o}, 32'd0);
`ifdef I2S_SLAVE_RX_FIFO_EN
    chk("overrun_cnt", n_over, 32'd0);
`else
    chk("overrun_cnt", n_over, 32'd1);
`endif
    bus_if.sample_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    push(1'b0, 32'h000F0F0F);
    send_slot(1'b0, 24'h0F0F0F, 24, 7, 1'b0);
    bus_if.sample_ready_i = 1'b0;
    push(1'b1, 32'h005A5A5A);
    send_slot(1'b1, 24'h5A5A5A, 24, 7, 1'b0);
    send_slot(1'b0, 24'hFFF000, 10, 0, 1'b0);
    chk("pre_rst_valid", {31'b0, bus_if.sample_valid_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, bus_if.sample_valid_o}, 32'd0);
    chk("mid_rst_dat", bus_if.sample_dat_o, 32'd0);
    chk("mid_rst_ch", {31'b0, bus_if.sample_ch_o}, 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    bus_if.sample_ready_i = 1'b1;
    push(1'b1, 32'hFFC0FFEE);
    send_slot(1'b1, 24'hC0FFEE, 24, 7, 1'b0);
    push(1'b0, 32'h003C3C3C);
    send_slot(1'b0, 24'h3C3C3C, 24, 7, 1'b0);
    send_slot(1'b1, 24'hFFFFFF, 10, 0, 1'b0);
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("en_low_valid", {31'b0, bus_if.sample_valid_o}, 32'd0);
    en = 1'b1;
    send_slot(1'b1, 24'h000000, 0, 21, 1'b0);
    push(1'b0, 32'h0013579B);
    send_slot(1'b0, 24'h13579B, 24, 7, 1'b0);
    push(1'b1, 32'hFFEDCBA9);
    send_slot(1'b1, 24'hEDCBA9, 24, 7, 1'b0);
    repeat (20) @(negedge clk);
    chk("sb_left", sb.size(), 32'd0);
    chk("short_total", n_short, 32'd1);
`ifdef I2S_SLAVE_RX_FIFO_EN
    chk("overrun_total", n_over, 32'd0);
`else
    chk("overrun_total", n_over, 32'd1);
`endif
    chk("end_valid", {31'b0, bus_if.sample_valid_o}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
